bcd_ascii_serializer: RTL and testbench

BCD_ASCII_SERIALIZER -- requirements
Module: bcd_ascii_serializer

---
 rtl/bcd_ascii_serializer.sv | 131 +++++++++++++
 tb/tb_bcd_ascii_serializer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_ascii_serializer.sv
// Serializes a latched frame of 4-bit digits into ASCII bytes for a TX FIFO.
// Supports optional leading-zero suppression, hex letters and a CR/LF trailer.
module bcd_ascii_serializer #(
  parameter int         NUM_DIGITS   = 4,
  parameter int         HEX_MODE     = 0,
  parameter logic [7:0] INVALID_CHAR = 8'h30,
  parameter int         LZ_SUPPRESS  = 1,
  parameter int         APPEND_CRLF  = 1
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic                    iStart,
  input  logic [4*NUM_DIGITS-1:0] iBcd,
  input  logic                    iTxFull,
  output logic                    oWrEn,
  output logic [7:0]              oData,
  output logic                    oBusy,
  output logic                    oDone
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIG,
    S_CR,
    S_LF,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [4*NUM_DIGITS-1:0] frame_q, frame_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    lz_q, lz_d;

  logic [3:0]              cur_nib;
  logic                    skip_digit;

  function automatic logic [7:0] encode(input logic [3:0] nib);
    if (nib <= 4'd9) begin
      return {4'h3, nib};
    end else if (HEX_MODE != 0) begin
      return 8'h37 + {4'h0, nib};
    end else begin
      return INVALID_CHAR;
    end
  endfunction

  assign cur_nib    = frame_q[{idx_q, 2'b00} +: 4];
  // The least significant digit is never skipped, so an all-zero frame still prints "0".
  assign skip_digit = lz_q && (cur_nib == 4'd0) && (idx_q != '0);
  assign oBusy      = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    idx_d   = idx_q;
    lz_d    = lz_q;
    oWrEn   = 1'b0;
    oData   = 8'h00;
    oDone   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (iStart) begin
          frame_d = iBcd;
          idx_d   = IDX_W'(NUM_DIGITS - 1);
          lz_d    = (LZ_SUPPRESS != 0);
          state_d = S_DIG;
        end
      end

      S_DIG: begin
        if (skip_digit) begin
          idx_d = idx_q - IDX_W'(1);
        end else begin
          lz_d  = 1'b0;
          oData = encode(cur_nib);
          oWrEn = !iTxFull;
          if (!iTxFull) begin
            if (idx_q == '0) begin
              state_d = (APPEND_CRLF != 0) ? S_CR : S_DONE;
            end else begin
              idx_d = idx_q - IDX_W'(1);
            end
          end
        end
      end

      S_CR: begin
        oData = 8'h0D;
        oWrEn = !iTxFull;
        if (!iTxFull) begin
          state_d = S_LF;
        end
      end

      S_LF: begin
        oData = 8'h0A;
        oWrEn = !iTxFull;
        if (!iTxFull) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        oDone   = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= S_IDLE;
      frame_q <= '0;
      idx_q   <= '0;
      lz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      idx_q   <= idx_d;
      lz_q    <= lz_d;
    end
  end

endmodule

// File: tb/tb_bcd_ascii_serializer.sv
// Self-checking bench: a decimal and a hex-mode serializer share stimulus and are
// compared cycle by cycle against a byte-queue model of the expected frame.
module tb_bcd_ascii_serializer;

  logic        iClk;
  logic        iRst;
  logic        iStart;
  logic [15:0] iBcd;
  logic        iTxFull;

  logic        wrEn, busy, done;
  logic [7:0]  data;
  logic        wrEnH, busyH, doneH;
  logic [7:0]  dataH;

  int checks = 0;
  int errors = 0;

  logic [7:0] expQ[$];
  logic [7:0] expHexQ[$];
  int         skipCnt;

  bcd_ascii_serializer dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iStart (iStart),
    .iBcd   (iBcd),
    .iTxFull(iTxFull),
    .oWrEn  (wrEn),
    .oData  (data),
    .oBusy  (busy),
    .oDone  (done)
  );

  bcd_ascii_serializer #(.HEX_MODE(1)) dutHex (
    .iClk   (iClk),
    .iRst   (iRst),
    .iStart (iStart),
    .iBcd   (iBcd),
    .iTxFull(iTxFull),
    .oWrEn  (wrEnH),
    .oData  (dataH),
    .oBusy  (busyH),
    .oDone  (doneH)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Both instances must look idle/reset.
  task automatic checkIdle(input string tag);
    checkOutput({tag, "_wr"},    {7'd0, wrEn},  8'h00);
    checkOutput({tag, "_data"},  data,          8'h00);
    checkOutput({tag, "_busy"},  {7'd0, busy},  8'h00);
    checkOutput({tag, "_done"},  {7'd0, done},  8'h00);
    checkOutput({tag, "_wrH"},   {7'd0, wrEnH}, 8'h00);
    checkOutput({tag, "_dataH"}, dataH,         8'h00);
    checkOutput({tag, "_busyH"}, {7'd0, busyH}, 8'h00);
    checkOutput({tag, "_doneH"}, {7'd0, doneH}, 8'h00);
  endtask

  // Expected output: digits MSD first, leading zeros dropped (last digit kept), then CR LF.
  task automatic buildModel(input logic [15:0] bcd);
    bit leading;
    expQ.delete();
    expHexQ.delete();
    skipCnt = 0;
    leading = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      int d;
      d = (int'(bcd) >> (4 * i)) & 15;
      if (leading && d == 0 && i != 0) begin
        skipCnt++;
      end else begin
        leading = 1'b0;
        expQ.push_back(d < 10 ? 8'(48 + d) : 8'h30);
        expHexQ.push_back(d < 10 ? 8'(48 + d) : 8'(65 + d - 10));
      end
    end
    expQ.push_back(8'h0D);
    expQ.push_back(8'h0A);
    expHexQ.push_back(8'h0D);
    expHexQ.push_back(8'h0A);
  endtask

  // stallMode: 0 never full, 1 random full, 2 full for 3 cycles while the 2nd byte is pending.
  // restart: raise iStart with a different iBcd in the middle of the frame.
  task automatic applyStimulus(input logic [15:0] bcd, input int stallMode, input bit restart);
    int  cyc;
    int  written;
    int  stalls;
    bit  doneSeen;
    buildModel(bcd);
    @(negedge iClk);
    iStart  = 1'b1;
    iBcd    = bcd;
    iTxFull = 1'b0;
    @(negedge iClk);
    iStart   = 1'b0;
    iBcd     = 16'($urandom);
    cyc      = 0;
    written  = 0;
    stalls   = 0;
    doneSeen = 1'b0;
    while (!doneSeen && cyc < 100) begin
      case (stallMode)
        1:       iTxFull = ($urandom_range(0, 2) == 0);
        2:       iTxFull = (written == 1 && stalls < 3);
        default: iTxFull = 1'b0;
      endcase
      if (iTxFull && stallMode == 2) stalls++;
      if (restart && cyc == 2) begin
        iStart = 1'b1;
        iBcd   = ~bcd;
      end else begin
        iStart = 1'b0;
      end
      #1;
      if (skipCnt > 0) begin
        checkOutput("skip_wr",    {7'd0, wrEn},  8'h00);
        checkOutput("skip_data",  data,          8'h00);
        checkOutput("skip_busy",  {7'd0, busy},  8'h01);
        checkOutput("skip_wrH",   {7'd0, wrEnH}, 8'h00);
        skipCnt--;
      end else if (expQ.size() > 0) begin
        checkOutput("byte_data",  data,          expQ[0]);
        checkOutput("byte_dataH", dataH,         expHexQ[0]);
        checkOutput("byte_wr",    {7'd0, wrEn},  {7'd0, !iTxFull});
        checkOutput("byte_wrH",   {7'd0, wrEnH}, {7'd0, !iTxFull});
        checkOutput("byte_busy",  {7'd0, busy},  8'h01);
        checkOutput("byte_done",  {7'd0, done},  8'h00);
        if (!iTxFull) begin
          void'(expQ.pop_front());
          void'(expHexQ.pop_front());
          written++;
        end
      end else begin
        checkOutput("done_pulse", {7'd0, done},  8'h01);
        checkOutput("done_pulseH",{7'd0, doneH}, 8'h01);
        checkOutput("done_wr",    {7'd0, wrEn},  8'h00);
        checkOutput("done_data",  data,          8'h00);
        checkOutput("done_busy",  {7'd0, busy},  8'h01);
        doneSeen = 1'b1;
      end
      cyc++;
      @(negedge iClk);
    end
    checkOutput("frame_timeout", {7'd0, doneSeen}, 8'h01);
    iStart  = 1'b0;
    iTxFull = 1'b0;
    #1;
    checkIdle("after_frame");
  endtask

  initial begin
    iRst    = 1'b1;
    iStart  = 1'b0;
    iBcd    = 16'h0000;
    iTxFull = 1'b0;
    #2;
    checkIdle("reset");
    @(negedge iClk);
    @(negedge iClk);
    iRst = 1'b0;

    applyStimulus(16'h1234, 0, 1'b0);
    applyStimulus(16'h0050, 0, 1'b0);
    applyStimulus(16'h0000, 0, 1'b0);
    applyStimulus(16'h12A4, 0, 1'b0);
    applyStimulus(16'h1234, 2, 1'b0);
    applyStimulus(16'h1234, 0, 1'b1);
    applyStimulus(16'h0F0B, 1, 1'b1);

    // Abort a frame with reset right after its second byte is written.
    @(negedge iClk);
    iStart = 1'b1;
    iBcd   = 16'h1234;
    @(negedge iClk);
    iStart = 1'b0;
    #1;
    checkOutput("abort_byte1", data, 8'h31);
    @(negedge iClk);
    #1;
    checkOutput("abort_byte2", data, 8'h32);
    checkOutput("abort_wr2",   {7'd0, wrEn}, 8'h01);
    @(posedge iClk);
    #2;
    iRst = 1'b1;
    #1;
    checkIdle("abort_async");
    @(negedge iClk);
    #1;
    checkIdle("abort_hold");
    iRst = 1'b0;
    @(negedge iClk);
    #1;
    checkIdle("abort_release");
    applyStimulus(16'h0007, 0, 1'b0);

    for (int n = 0; n < 25; n++) begin
      logic [15:0] v;
      int          nz;
      v  = 16'($urandom);
      nz = $urandom_range(0, 4);
      if (nz > 0) v = v & (16'hFFFF >> (4 * nz));
      applyStimulus(v, 1, ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
